// File: rtl/rf_wb_queue.sv
// Register-file write-back queue: in-order buffer of ALU/LSU results draining one write per cycle.
// Optional bypass lookup enabled by defining RF_WB_FWD_EN.
module rf_wb_queue #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ALU_VALID,
    output logic                 ALU_READY,
    input  logic [AW-1:0]        ALU_RD,
    input  logic [XLEN-1:0]      ALU_DATA,
    input  logic                 LSU_VALID,
    output logic                 LSU_READY,
    input  logic [AW-1:0]        LSU_RD,
    input  logic [XLEN-1:0]      LSU_DATA,
    output logic                 WRITE_ENABLE,
    output logic [AW-1:0]        WRITE_ADDRESS,
    output logic [XLEN-1:0]      WRITE_DATA,
    output logic [(1<<AW)-1:0]   BUSY,
    output logic                 EMPTY,
    input  logic [AW-1:0]        FWD_ADDR1,
    input  logic [AW-1:0]        FWD_ADDR2,
    output logic                 FWD_HIT1,
    output logic [XLEN-1:0]      FWD_DATA1,
    output logic                 FWD_HIT2,
    output logic [XLEN-1:0]      FWD_DATA2
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << AW;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_ent_t;

    wb_ent_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, free, n_push;
    logic          lsu_push, alu_push, pop, out_en;
    wb_ent_t       head;
    logic [NREG-1:0] busy_q;

    // Ready depends only on registered count and LSU_VALID; a pop this cycle is not credited.
    assign free      = CW'(DEPTH) - count;
    assign LSU_READY = (free >= CW'(1));
    assign ALU_READY = (free >= CW'(2)) | ((free >= CW'(1)) & ~LSU_VALID);

    assign lsu_push = LSU_VALID & LSU_READY & (LSU_RD != '0);
    assign alu_push = ALU_VALID & ALU_READY & (ALU_RD != '0);
    assign n_push   = CW'(lsu_push) + CW'(alu_push);
    assign pop      = (count != '0);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count  <= count + n_push - CW'(pop);
        end
    end

    // LSU entry is older when both land in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST_N && lsu_push) mem[wr_ptr] <= '{rd: LSU_RD, data: LSU_DATA};
        if (RST_N && alu_push) mem[wr_ptr + PW'(lsu_push)] <= '{rd: ALU_RD, data: ALU_DATA};
    end

    assign head          = mem[rd_ptr];
    assign out_en        = RST_N & (count != '0);
    assign WRITE_ENABLE  = out_en;
    assign WRITE_ADDRESS = out_en ? head.rd   : '0;
    assign WRITE_DATA    = out_en ? head.data : '0;
    assign EMPTY         = (count == '0) | ~RST_N;

    always_comb begin
        busy_q = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) busy_q[mem[rd_ptr + PW'(k)].rd] = 1'b1;
        end
        busy_q[0] = 1'b0;
        BUSY = RST_N ? busy_q : '0;
    end

`ifdef RF_WB_FWD_EN
    // Walk oldest to youngest so the last match is the youngest writer.
    always_comb begin
        FWD_HIT1  = 1'b0;
        FWD_DATA1 = '0;
        FWD_HIT2  = 1'b0;
        FWD_DATA2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (RST_N && (CW'(k) < count)) begin
                if (FWD_ADDR1 != '0 && mem[rd_ptr + PW'(k)].rd == FWD_ADDR1) begin
                    FWD_HIT1  = 1'b1;
                    FWD_DATA1 = mem[rd_ptr + PW'(k)].data;
                end
                if (FWD_ADDR2 != '0 && mem[rd_ptr + PW'(k)].rd == FWD_ADDR2) begin
                    FWD_HIT2  = 1'b1;
                    FWD_DATA2 = mem[rd_ptr + PW'(k)].data;
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{FWD_ADDR1, FWD_ADDR2};
    assign FWD_HIT1   = 1'b0;
    assign FWD_DATA1  = '0;
    assign FWD_HIT2   = 1'b0;
    assign FWD_DATA2  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue: queue-based reference model, directed scenarios then random traffic.
module tb_rf_wb_queue;
    localparam int XLEN = 32, AW = 5, DEPTH = 4;

    logic            CLK, RST_N;
    logic            ALU_VALID, ALU_READY, LSU_VALID, LSU_READY;
    logic [AW-1:0]   ALU_RD, LSU_RD, WRITE_ADDRESS, FWD_ADDR1, FWD_ADDR2;
    logic [XLEN-1:0] ALU_DATA, LSU_DATA, WRITE_DATA, FWD_DATA1, FWD_DATA2;
    logic            WRITE_ENABLE, EMPTY, FWD_HIT1, FWD_HIT2;
    logic [31:0]     BUSY;

    rf_wb_queue #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
        .LSU_VALID(LSU_VALID), .LSU_READY(LSU_READY), .LSU_RD(LSU_RD), .LSU_DATA(LSU_DATA),
        .WRITE_ENABLE(WRITE_ENABLE), .WRITE_ADDRESS(WRITE_ADDRESS), .WRITE_DATA(WRITE_DATA),
        .BUSY(BUSY), .EMPTY(EMPTY),
        .FWD_ADDR1(FWD_ADDR1), .FWD_ADDR2(FWD_ADDR2),
        .FWD_HIT1(FWD_HIT1), .FWD_DATA1(FWD_DATA1),
        .FWD_HIT2(FWD_HIT2), .FWD_DATA2(FWD_DATA2)
    );

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t q[$];
    int   model_cnt = 0;
    int   n_tests = 0, n_fail = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected bypass: youngest pending write to a nonzero register.
    task automatic fwd_model(input logic [AW-1:0] a, output logic hit, output logic [XLEN-1:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (q[i]) if (a != '0 && q[i].rd == a) begin hit = 1'b1; d = q[i].d; end
    endtask

    // Monitor: everything in q is what the DUT holds; head is written at the next edge.
    always @(negedge CLK) begin
        int          n;
        logic [31:0] exp_busy;
        logic        h;
        logic [XLEN-1:0] fd;
        n = q.size();
        exp_busy = '0;
        foreach (q[i]) exp_busy[q[i].rd] = 1'b1;
        chk("empty", 32'(EMPTY), 32'(n == 0));
        chk("write_enable", 32'(WRITE_ENABLE), 32'(n != 0));
        chk("busy", BUSY, exp_busy);
        if (n != 0) begin
            chk("write_address", 32'(WRITE_ADDRESS), 32'(q[0].rd));
            chk("write_data", WRITE_DATA, q[0].d);
        end else begin
            chk("idle_address", 32'(WRITE_ADDRESS), 32'd0);
            chk("idle_data", WRITE_DATA, 32'd0);
        end
        if (RST_N) begin
            chk("lsu_ready", 32'(LSU_READY), 32'(n < DEPTH));
            chk("alu_ready", 32'(ALU_READY),
                32'((DEPTH - n >= 2) || (n < DEPTH && !LSU_VALID)));
        end
`ifdef RF_WB_FWD_EN
        fwd_model(FWD_ADDR1, h, fd);
        chk("fwd_hit1", 32'(FWD_HIT1), 32'(h));
        chk("fwd_data1", FWD_DATA1, fd);
        fwd_model(FWD_ADDR2, h, fd);
        chk("fwd_hit2", 32'(FWD_HIT2), 32'(h));
        chk("fwd_data2", FWD_DATA2, fd);
`else
        fwd_model(FWD_ADDR1, h, fd);
        chk("fwd_hit1_off", 32'(FWD_HIT1), 32'd0);
        chk("fwd_hit2_off", 32'(FWD_HIT2), 32'd0);
`endif
        model_cnt = n;
        if (n != 0) void'(q.pop_front());
    end

    // One cycle of stimulus; expected writes are queued from the model's own occupancy.
    task automatic cyc(input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld,
                       input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                       input logic [AW-1:0] f1, input logic [AW-1:0] f2);
        int free;
        @(posedge CLK); #1;
        LSU_VALID = lv; LSU_RD = lrd; LSU_DATA = ld;
        ALU_VALID = av; ALU_RD = ard; ALU_DATA = ad;
        FWD_ADDR1 = f1; FWD_ADDR2 = f2;
        @(negedge CLK); #1;
        free = DEPTH - model_cnt;
        if (lv && free >= 1 && lrd != '0) q.push_back('{lrd, ld});
        if (av && (free >= 2 || (free >= 1 && !lv)) && ard != '0) q.push_back('{ard, ad});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, '0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        @(posedge CLK); #1;
        RST_N = 1'b0;
        LSU_VALID = 1'b0; ALU_VALID = 1'b0;
        q.delete();
        repeat (n) @(posedge CLK);
        #1 RST_N = 1'b1;
        model_cnt = 0;
    endtask

    initial begin
        RST_N = 1'b0;
        ALU_VALID = 1'b0; ALU_RD = '0; ALU_DATA = '0;
        LSU_VALID = 1'b0; LSU_RD = '0; LSU_DATA = '0;
        FWD_ADDR1 = '0; FWD_ADDR2 = '0;
        do_reset(2);
        idle(3);
        cyc(0, '0, '0, 1, 5'd5, 32'hDEADBEEF, 5'd5, '0);
        idle(2);
        cyc(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, '0, '0);
        idle(3);
        for (int i = 0; i < 6; i++)
            cyc(1, AW'(i + 1), 32'(i * 3 + 100), 1, AW'(i + 10), 32'(i * 7 + 200), AW'(i + 1), AW'(i + 10));
        idle(4);
        cyc(0, '0, '0, 1, 5'd0, 32'h55, '0, '0);
        idle(2);
        cyc(1, 5'd7, 32'd1, 1, 5'd7, 32'd2, 5'd7, '0);
        cyc(0, '0, '0, 0, '0, '0, 5'd7, 5'd0);
        idle(3);
        cyc(1, 5'd8, 32'h81, 1, 5'd9, 32'h91, '0, '0);
        cyc(1, 5'd10, 32'hA1, 1, 5'd11, 32'hB1, '0, '0);
        do_reset(1);
        idle(3);
        for (int i = 0; i < 500; i++) begin
            if (i == 250) do_reset(1);
            cyc(($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), $urandom,
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        idle(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
